booth_inverse_divider: RTL and testbench

//  Sequential non-restoring divider; arithmetic inverse of the Booth multiplier array.

---
 rtl/booth_inverse_divider.sv | 146 ++++++++++++++
 tb/tb_booth_inverse_divider.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_inverse_divider.sv
// booth_inverse_divider
//   Sequential non-restoring divider: 2W-bit dividend / W-bit divisor ->
//   W-bit quotient and remainder, one iteration per clock, with a
//   start/busy/done handshake.
//   Optional build macro DIVIDER_SIGNED_EN: two's complement operands with
//   truncating division; the unsigned core runs on the operand magnitudes.
module booth_inverse_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [W-1:0] LAST_ITER = W'(W - 1);

  state_t         state;
  logic [W:0]     p;        // partial remainder, two's complement
  logic [W-1:0]   qreg;     // low dividend bits shifting out, quotient bits in
  logic [W-1:0]   dreg;     // divisor (magnitude) captured on accept
  logic [W-1:0]   cnt;      // iteration counter

  logic [2*W-1:0] dd_mag;
  logic [W-1:0]   d_mag;
  logic [W:0]     p_shift;
  logic [W:0]     p_next;
  logic [W:0]     p_fix;

`ifdef DIVIDER_SIGNED_EN
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

  logic sign_q;   // quotient is negative (operand signs differ)
  logic sign_r;   // remainder is negative (dividend was negative)

  // Operand magnitudes; the most negative values still fit as unsigned.
  always_comb begin
    dd_mag = dividend[2*W-1] ? -dividend : dividend;
    d_mag  = divisor[W-1]    ? -divisor  : divisor;
  end
`else
  assign dd_mag = dividend;
  assign d_mag  = divisor;
`endif

  // One non-restoring step and the final remainder correction.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    p_shift = {p[W-1:0], qreg[W-1]};
    p_next  = p[W] ? p_shift + {1'b0, dreg} : p_shift - {1'b0, dreg};
    p_fix   = p[W] ? p + {1'b0, dreg} : p;
  end

  // Control FSM, datapath registers and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      qreg      <= '0;
      dreg      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            div_zero <= 1'b0;
            overflow <= 1'b0;
            dreg     <= d_mag;
`ifdef DIVIDER_SIGNED_EN
            sign_q   <= dividend[2*W-1] ^ divisor[W-1];
            sign_r   <= dividend[2*W-1];
`endif
            if (d_mag == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else if (dd_mag[2*W-1:W] >= d_mag) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              overflow  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              p     <= {1'b0, dd_mag[2*W-1:W]};
              qreg  <= dd_mag[W-1:0];
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          p    <= p_next;
          qreg <= {qreg[W-2:0], ~p_next[W]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
          if ((!sign_q && qreg > POS_MAX) || (sign_q && qreg > NEG_MAX)) begin
            overflow  <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
          end else begin
            quotient  <= sign_q ? -qreg : qreg;
            remainder <= sign_r ? -p_fix[W-1:0] : p_fix[W-1:0];
          end
`else
          quotient  <= qreg;
          remainder <= p_fix[W-1:0];
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_inverse_divider.sv
// tb_booth_inverse_divider
//   Scoreboard bench: each issued division pushes its expected result and
//   latency; the entry is popped and compared when done is seen.
//   Compile with +define+DIVIDER_SIGNED_EN to exercise the signed build.
module tb_booth_inverse_divider;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  booth_inverse_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference result from integer division.
  function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] d);
    exp_t e;
`ifdef DIVIDER_SIGNED_EN
    longint sdd, sd, mdd, md, qm, rm;
    bit     neg;
`endif
    e.q = '1; e.r = '0; e.dz = 1'b0; e.ov = 1'b0; e.lat = W + 2;
`ifdef DIVIDER_SIGNED_EN
    sdd = longint'($signed(dd));
    sd  = longint'($signed(d));
    mdd = (sdd < 0) ? -sdd : sdd;
    md  = (sd < 0) ? -sd : sd;
    if (md == 0) begin
      e.dz = 1'b1; e.lat = 1;
    end else if ((mdd >> W) >= md) begin
      e.ov = 1'b1; e.lat = 1;
    end else begin
      qm  = mdd / md;
      rm  = mdd % md;
      neg = (sdd < 0) != (sd < 0);
      if (qm > (neg ? longint'(1 << (W-1)) : longint'((1 << (W-1)) - 1))) e.ov = 1'b1;
      else begin
        e.q = W'(neg ? -qm : qm);
        e.r = W'((sdd < 0) ? -rm : rm);
      end
    end
`else
    if (d == 0) begin
      e.dz = 1'b1; e.lat = 1;
    end else if ((dd >> W) >= d) begin
      e.ov = 1'b1; e.lat = 1;
    end else begin
      e.q = W'(dd / d);
      e.r = W'(dd % d);
    end
`endif
    return e;
  endfunction

  // Drive a request at the current negedge and record its expectation.
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] d);
    start    = 1'b1;
    dividend = dd;
    divisor  = d;
    sb.push_back(model(dd, d));
  endtask

  // Wait for done (bounded); pulse a stray start after edges na/nb.
  // Returns at the negedge of the done cycle.
  task automatic wait_done(input int na, input int nb, input string tag);
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == na) || (n == nb);
      if (start) begin
        dividend = '1;
        divisor  = '0;
      end
      if (n == 1 && sb.size() > 0 && sb[0].lat > 1) begin
        check({tag, ".busy_early"}, busy, 1);
        check({tag, ".done_early"}, done, 0);
      end
      if (done) seen = 1'b1;
    end
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 0, 1);
    end else if (!seen) begin
      e = sb.pop_front();
      check({tag, ".timeout"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, ".latency"},   n, e.lat);
      check({tag, ".quotient"},  quotient, e.q);
      check({tag, ".remainder"}, remainder, e.r);
      check({tag, ".div_zero"},  div_zero, e.dz);
      check({tag, ".overflow"},  overflow, e.ov);
      check({tag, ".busy_done"}, busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] rdd;
    logic [W-1:0]   rd;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1 rst = 1'b1;
    #1;
    check("reset.busy",      busy, 0);
    check("reset.done",      done, 0);
    check("reset.quotient",  quotient, 0);
    check("reset.remainder", remainder, 0);
    check("reset.div_zero",  div_zero, 0);
    check("reset.overflow",  overflow, 0);
    @(negedge clk) rst = 1'b0;

    @(negedge clk) issue(16'd1000, 8'd7);
    wait_done(0, 0, "div_1000_7");

    @(negedge clk) issue(16'd300, 8'd0);
    wait_done(0, 0, "div_zero");
    @(negedge clk);
    check("div_zero.done_pulse", done, 0);
    check("div_zero.flag_held",  div_zero, 1);

    issue(16'h1234, 8'h12);
    wait_done(0, 0, "overflow");

    // Stray starts while busy are ignored; start in the DONE cycle is taken.
    @(negedge clk) issue(16'd1000, 8'd7);
    wait_done(3, 9, "ignored_starts");
    issue(16'd65025, 8'd255);
    wait_done(0, 0, "back_to_back");

    // Reset during CALC iteration 4 abandons the operation.
    @(negedge clk) issue(16'd1000, 8'd7);
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    void'(sb.pop_back());
    #1;
    check("mid_reset.busy",      busy, 0);
    check("mid_reset.done",      done, 0);
    check("mid_reset.quotient",  quotient, 0);
    check("mid_reset.remainder", remainder, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("mid_reset.no_done", done, 0);
    end
    issue(16'd1000, 8'd7);
    wait_done(0, 0, "after_reset");

`ifdef DIVIDER_SIGNED_EN
    @(negedge clk) issue(16'hFF9C, 8'h07);
    wait_done(0, 0, "signed_m100_7");
    check("signed_m100_7.q_const", quotient, 8'hF2);
    check("signed_m100_7.r_const", remainder, 8'hFE);
    @(negedge clk) issue(16'h8000, 8'h01);
    wait_done(0, 0, "signed_min_1");
    check("signed_min_1.ov_const", overflow, 1);
`else
    check("div_1000_7.q_const", quotient, 8'd142);
    check("div_1000_7.r_const", remainder, 8'd6);
`endif

    // Random operands, biased toward the iterative path, some back-to-back.
    for (int i = 0; i < 30; i++) begin
      rd  = W'($urandom_range(0, (1 << W) - 1));
      rdd = (2*W)'($urandom);
      if (i % 3 != 0 && rd != 0) rdd[2*W-1:W] = W'($urandom_range(0, int'(rd) - 1));
      if (i % 4 != 0) @(negedge clk);
      issue(rdd, rd);
      wait_done(0, 0, "random");
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
